// File: rtl/db15_snac_scanner.sv
// DB15 SNAC adapter scanner: clocks the adapter's 32-bit shift chain and publishes
// both 16-bit button words only after two consecutive identical frames.
module db15_snac_scanner #(
   parameter int CLK_DIV   = 16,
   parameter int GAP_TICKS = 64
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        enable,
   input  logic        joy_data,
   output logic        joy_clk,
   output logic        joy_load,
   output logic [15:0] joystick1,
   output logic [15:0] joystick2,
   output logic        frame_valid
);

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_LOAD     = 3'd1;
   localparam logic [2:0] ST_SHIFT_LO = 3'd2;
   localparam logic [2:0] ST_SHIFT_HI = 3'd3;
   localparam logic [2:0] ST_COMMIT   = 3'd4;

   localparam int PW = 8;
   localparam int GW = 10;
   localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
   localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_TICKS - 1);

   logic [1:0]    sync_q;
   logic [PW-1:0] presc_q;
   logic          tick_s;

   logic [2:0]    state_q, state_d;
   logic [GW-1:0] gap_q, gap_d;
   logic [4:0]    idx_q, idx_d;
   logic [31:0]   capture_q, capture_d;
   logic [31:0]   prev_capture_q, prev_capture_d;
   logic          prev_valid_q, prev_valid_d;
   logic          joy_clk_q, joy_clk_d;
   logic          joy_load_q, joy_load_d;
   logic [15:0]   joy1_q, joy1_d;
   logic [15:0]   joy2_q, joy2_d;
   logic          fv_q, fv_d;

   // Two-flop synchroniser for the asynchronous adapter data line.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= 2'b00;
      end else begin
         sync_q <= {sync_q[0], joy_data};
      end
   end

   // Free-running prescaler producing the scan tick.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         presc_q <= '0;
      end else if (presc_q == PRESC_LAST) begin
         presc_q <= '0;
      end else begin
         presc_q <= presc_q + 8'd1;
      end
   end

   assign tick_s = (presc_q == PRESC_LAST);

   // Scan sequencer next-state and output logic.
   always_comb begin
      state_d        = state_q;
      gap_d          = gap_q;
      idx_d          = idx_q;
      capture_d      = capture_q;
      prev_capture_d = prev_capture_q;
      prev_valid_d   = prev_valid_q;
      joy_clk_d      = joy_clk_q;
      joy_load_d     = joy_load_q;
      joy1_d         = joy1_q;
      joy2_d         = joy2_q;
      fv_d           = 1'b0;
      if (!enable) begin
         // Abort any frame in flight; the next scan must re-establish a match.
         state_d      = ST_IDLE;
         gap_d        = '0;
         idx_d        = 5'd0;
         capture_d    = 32'h0000_0000;
         prev_valid_d = 1'b0;
         joy_clk_d    = 1'b0;
         joy_load_d   = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               joy_clk_d  = 1'b0;
               joy_load_d = 1'b1;
               if (tick_s && (gap_q == GAP_LAST)) begin
                  gap_d      = '0;
                  joy_load_d = 1'b0;
                  state_d    = ST_LOAD;
               end else if (tick_s) begin
                  gap_d = gap_q + 10'd1;
               end else begin
                  gap_d = gap_q;
               end
            end
            ST_LOAD: begin
               if (tick_s) begin
                  joy_load_d = 1'b1;
                  idx_d      = 5'd0;
                  state_d    = ST_SHIFT_LO;
               end else begin
                  joy_load_d = 1'b0;
               end
            end
            ST_SHIFT_LO: begin
               if (tick_s) begin
                  // Adapter lines are active low; store buttons as active high.
                  capture_d[idx_q] = ~sync_q[1];
                  joy_clk_d        = 1'b1;
                  state_d          = ST_SHIFT_HI;
               end else begin
                  joy_clk_d = 1'b0;
               end
            end
            ST_SHIFT_HI: begin
               if (tick_s && (idx_q == 5'd31)) begin
                  joy_clk_d = 1'b0;
                  state_d   = ST_COMMIT;
               end else if (tick_s) begin
                  joy_clk_d = 1'b0;
                  idx_d     = idx_q + 5'd1;
                  state_d   = ST_SHIFT_LO;
               end else begin
                  joy_clk_d = 1'b1;
               end
            end
            ST_COMMIT: begin
               if ((capture_q == prev_capture_q) && prev_valid_q) begin
                  joy1_d = capture_q[15:0];
                  joy2_d = capture_q[31:16];
                  fv_d   = 1'b1;
               end else begin
                  fv_d = 1'b0;
               end
               prev_capture_d = capture_q;
               prev_valid_d   = 1'b1;
               gap_d          = '0;
               state_d        = ST_IDLE;
            end
            default: begin
               state_d    = ST_IDLE;
               gap_d      = '0;
               joy_clk_d  = 1'b0;
               joy_load_d = 1'b1;
            end
         endcase
      end
   end

   // Sequencer state and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= ST_IDLE;
         gap_q          <= '0;
         idx_q          <= 5'd0;
         capture_q      <= 32'h0000_0000;
         prev_capture_q <= 32'h0000_0000;
         prev_valid_q   <= 1'b0;
         joy_clk_q      <= 1'b0;
         joy_load_q     <= 1'b1;
         joy1_q         <= 16'h0000;
         joy2_q         <= 16'h0000;
         fv_q           <= 1'b0;
      end else begin
         state_q        <= state_d;
         gap_q          <= gap_d;
         idx_q          <= idx_d;
         capture_q      <= capture_d;
         prev_capture_q <= prev_capture_d;
         prev_valid_q   <= prev_valid_d;
         joy_clk_q      <= joy_clk_d;
         joy_load_q     <= joy_load_d;
         joy1_q         <= joy1_d;
         joy2_q         <= joy2_d;
         fv_q           <= fv_d;
      end
   end

   assign joy_clk     = joy_clk_q;
   assign joy_load    = joy_load_q;
   assign joystick1   = joy1_q;
   assign joystick2   = joy2_q;
   assign frame_valid = fv_q;

endmodule
